timer_prescaler_ctrl: RTL and testbench
=======================================

TIMER_PRESCALER_CTRL -- requirements
Module: timer_prescaler_ctrl

Interface
REQ-001 SHALL have parameter DIV_W, default 4: width of div_val.
REQ-002 SHALL have parameter MAX_SHIFT, default 8: maximum division 2^MAX_SHIFT; prescaler counter width = MAX_SHIFT.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port timer_en  input  1  timer enable.
REQ-006 SHALL have port div_en  input  1  prescaler enable.
REQ-007 SHALL have port div_val  input  DIV_W  requested divide exponent.
REQ-008 SHALL have port halt_req  input  1  debug halt request.
REQ-009 SHALL have port dbg_mode  input  1  debug mode qualifier.
REQ-010 SHALL have port cnt_en  output  1  one-cycle count pulse to the main counter.
REQ-011 SHALL have port halt_ack  output  1  registered halt acknowledge.
REQ-012 SHALL have port state  output  2  FSM state: 00 IDLE, 01 RUN, 10 HALTED.
REQ-013 SHALL have port pre_cnt  output  MAX_SHIFT  current prescaler count.

Function
REQ-014 SHALL define hc = dbg_mode & halt_req (combinational).
REQ-015 SHALL define eff_shift = div_en ? min(div_active, MAX_SHIFT) : 0 and divisor D = 2^eff_shift; div_val above MAX_SHIFT saturates.
REQ-016 FSM priority per cycle: hc -> HALTED; else !timer_en -> IDLE; else -> RUN.
REQ-017 HALTED exit when hc drops: to RUN if timer_en=1, else IDLE; halt_ack SHALL equal 1 exactly while state=HALTED (asserts the cycle after hc first sampled high).
REQ-018 cnt_en SHALL be 1 iff state=RUN & timer_en & !hc & (pre_cnt >= D-1); never in IDLE or HALTED.
REQ-019 pre_cnt SHALL clear when !timer_en, or !div_en, or next state is IDLE.
REQ-020 pre_cnt SHALL hold its value while hc=1 or state=HALTED (no counting, no wrap).
REQ-021 In RUN with !hc: pre_cnt SHALL clear when pre_cnt >= D-1, else increment by 1; with D=1 pre_cnt stays 0 and cnt_en pulses every cycle.
REQ-022 Latency: timer_en rising in IDLE gives first cnt_en (D=1) one cycle later; with D>1, first cnt_en D cycles after entering RUN.
REQ-023 Divisor shrinking mid-period (pre_cnt already >= new D-1) SHALL produce one cnt_en then wrap to 0, never overrun.
REQ-024 Resume from HALTED SHALL continue from the held pre_cnt, preserving the partial period.

Reset
REQ-025 While rst=1: state=IDLE, pre_cnt=0, halt_ack=0, cnt_en=0, div_active=0; effect immediate, independent of clk.
REQ-026 Reset asserted mid-period SHALL discard the partial count; after release behaviour equals power-up.

Configuration
REQ-027 Macro TIMER_DIV_SHADOW_EN defined: div_active SHALL be a register loaded from div_val only while state=IDLE or on a cycle where cnt_en=1; div_val changes mid-period take effect on the next period.
REQ-028 Macro TIMER_DIV_SHADOW_EN undefined: div_active SHALL be div_val combinationally; changes take effect immediately under REQ-023.

Verification
REQ-029 timer_en=1, div_en=0 from reset -> cnt_en high every cycle from the cycle after entering RUN, pre_cnt=0 throughout.
REQ-030 div_en=1, div_val=3 -> cnt_en pulses once every 8 cycles, pre_cnt sequence 0..7 wrapping; div_val=15 with MAX_SHIFT=8 -> period 256.
REQ-031 div_val=2, pre_cnt=2, assert dbg_mode=halt_req=1 for 5 cycles -> halt_ack high 5 cycles starting next cycle, pre_cnt held at 2, no cnt_en; after release next cnt_en after remaining period (pre_cnt 2->3, pulse).
REQ-032 div_val=4, pre_cnt=10, change div_val to 2 -> without macro: cnt_en same cycle, pre_cnt->0, period 4 thereafter; with TIMER_DIV_SHADOW_EN: pulse at pre_cnt=15, then period 4.
REQ-033 Assert rst while pre_cnt=5 -> all outputs 0 and state IDLE immediately; after release with timer_en=1, RUN next cycle, count restarts at 0.
REQ-034 halt_req=1, dbg_mode=0 -> no halt, counting continues; timer_en dropped during HALTED -> remains HALTED until hc falls, then IDLE with pre_cnt=0.

Source files
------------

// File: rtl/timer_prescaler_ctrl.sv
// Timer prescaler controller: IDLE/RUN/HALTED FSM with a power-of-two prescaler that emits count pulses.
// Optional macro TIMER_DIV_SHADOW_EN makes the divide exponent update only at period boundaries.
module timer_prescaler_ctrl #(
  parameter int DIV_W     = 4,
  parameter int MAX_SHIFT = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 timer_en,
  input  logic                 div_en,
  input  logic [DIV_W-1:0]     div_val,
  input  logic                 halt_req,
  input  logic                 dbg_mode,
  output logic                 cnt_en,
  output logic                 halt_ack,
  output logic [1:0]           state,
  output logic [MAX_SHIFT-1:0] pre_cnt
);

  localparam int SH_W = $clog2(MAX_SHIFT + 1);
  localparam int CW   = MAX_SHIFT + 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_HALTED = 2'b10
  } state_t;

  state_t               r_state;
  state_t               w_next_state;
  logic [MAX_SHIFT-1:0] r_pre_cnt;
  logic [MAX_SHIFT-1:0] w_pre_nxt;
  logic [DIV_W-1:0]     w_div_active;
  logic [SH_W-1:0]      w_eff_shift;
  logic [CW-1:0]        w_d_m1;
  logic                 w_hc;
  logic                 w_wrap;
  logic                 w_cnt_en;

  assign w_hc = dbg_mode & halt_req;

`ifdef TIMER_DIV_SHADOW_EN
  logic [DIV_W-1:0] r_div_active;

  // Reload only at period boundaries so a mid-period change starts with the next period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_div_active <= '0;
    else if (r_state == ST_IDLE || w_cnt_en)
      r_div_active <= div_val;
  end

  assign w_div_active = r_div_active;
`else
  assign w_div_active = div_val;
`endif

  // Saturate the exponent so the divisor never exceeds the counter range.
  always_comb begin
    w_eff_shift = '0;
    if (div_en) begin
      if (32'(w_div_active) > MAX_SHIFT)
        w_eff_shift = SH_W'(MAX_SHIFT);
      else
        w_eff_shift = SH_W'(w_div_active);
    end
  end

  assign w_d_m1   = (CW'(1) << w_eff_shift) - CW'(1);
  // ">=" rather than "==" so a shrinking divisor wraps instead of overrunning.
  assign w_wrap   = ({1'b0, r_pre_cnt} >= w_d_m1);
  assign w_cnt_en = (r_state == ST_RUN) && timer_en && !w_hc && w_wrap;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_next_state = r_state;
    if (w_hc)
      w_next_state = ST_HALTED;
    else if (!timer_en)
      w_next_state = ST_IDLE;
    else
      w_next_state = ST_RUN;
  end

  // Halt dominates so the partial period survives; leaving HALTED to RUN also holds for one cycle.
  always_comb begin
    w_pre_nxt = r_pre_cnt;
    if (w_hc)
      w_pre_nxt = r_pre_cnt;
    else if (!timer_en || !div_en || w_next_state == ST_IDLE)
      w_pre_nxt = '0;
    else if (r_state == ST_HALTED)
      w_pre_nxt = r_pre_cnt;
    else if (r_state == ST_RUN)
      w_pre_nxt = w_wrap ? '0 : r_pre_cnt + MAX_SHIFT'(1);
    else
      w_pre_nxt = '0;
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_pre_cnt <= '0;
    end else begin
      r_state   <= w_next_state;
      r_pre_cnt <= w_pre_nxt;
    end
  end

  assign cnt_en   = w_cnt_en;
  assign halt_ack = (r_state == ST_HALTED);
  assign state    = r_state;
  assign pre_cnt  = r_pre_cnt;

endmodule

// File: tb/tb_timer_prescaler_ctrl.sv
// Directed self-checking bench for timer_prescaler_ctrl in its default (non-shadow) build.
module tb_timer_prescaler_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       timer_en = 1'b0;
  logic       div_en = 1'b0;
  logic [3:0] div_val = 4'd0;
  logic       halt_req = 1'b0;
  logic       dbg_mode = 1'b0;
  logic       cnt_en;
  logic       halt_ack;
  logic [1:0] state;
  logic [7:0] pre_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  timer_prescaler_ctrl #(.DIV_W(4), .MAX_SHIFT(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .timer_en (timer_en),
    .div_en   (div_en),
    .div_val  (div_val),
    .halt_req (halt_req),
    .dbg_mode (dbg_mode),
    .cnt_en   (cnt_en),
    .halt_ack (halt_ack),
    .state    (state),
    .pre_cnt  (pre_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic expect_all(input string tag, input int st, input int pre, input int ce, input int ha);
    check({tag, ".state"},    int'(state),    st);
    check({tag, ".pre_cnt"},  int'(pre_cnt),  pre);
    check({tag, ".cnt_en"},   int'(cnt_en),   ce);
    check({tag, ".halt_ack"}, int'(halt_ack), ha);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int pulses;
    int first_idx;

    // Reset state
    #3;
    expect_all("reset", 0, 0, 0, 0);

    // D=1: pulse every cycle from the first RUN cycle
    tick();
    rst = 1'b0;
    timer_en = 1'b1;
    #1;
    expect_all("idle_en", 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      expect_all($sformatf("d1_%0d", i), 1, 0, 1, 0);
    end

    // D=8: pre_cnt 0..7 with a pulse at 7
    div_en  = 1'b1;
    div_val = 4'd3;
    #1;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("d8_pre_%0d", i), int'(pre_cnt), i % 8);
      check($sformatf("d8_ce_%0d", i), int'(cnt_en), (i % 8 == 7) ? 1 : 0);
      tick();
    end

    // div_val=15 saturates to 2^8 = 256
    div_val = 4'd15;
    #1;
    pulses = 0;
    first_idx = -1;
    for (int i = 0; i < 512; i++) begin
      if (cnt_en === 1'b1) begin
        pulses++;
        if (first_idx < 0) first_idx = i;
      end
      tick();
    end
    check("sat_pulses", pulses, 2);
    check("sat_first", first_idx, 255);
    check("sat_pre_end", int'(pre_cnt), 0);

    // Halt for 5 cycles at pre_cnt=2 with D=4
    div_val = 4'd2;
    #1;
    check("h_pre0", int'(pre_cnt), 0);
    tick();
    tick();
    expect_all("h_pre2", 1, 2, 0, 0);
    dbg_mode = 1'b1;
    halt_req = 1'b1;
    #1;
    expect_all("h_c0", 1, 2, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      expect_all($sformatf("h_c%0d", i), 2, 2, 0, 1);
    end
    tick();
    dbg_mode = 1'b0;
    halt_req = 1'b0;
    #1;
    expect_all("h_c5", 2, 2, 0, 1);
    tick();
    expect_all("h_resume", 1, 2, 0, 0);
    tick();
    expect_all("h_pulse", 1, 3, 1, 0);
    tick();
    expect_all("h_wrap", 1, 0, 0, 0);

    // Divisor shrinks 16 -> 4 at pre_cnt=10
    div_val = 4'd4;
    #1;
    for (int i = 0; i < 10; i++) tick();
    expect_all("shr_pre10", 1, 10, 0, 0);
    div_val = 4'd2;
    #1;
    check("shr_pulse", int'(cnt_en), 1);
    tick();
    expect_all("shr_wrap", 1, 0, 0, 0);
    tick();
    tick();
    tick();
    expect_all("shr_p4", 1, 3, 1, 0);
    tick();

    // halt_req without dbg_mode is ignored
    halt_req = 1'b1;
    #1;
    tick();
    expect_all("nohalt", 1, 1, 0, 0);
    halt_req = 1'b0;

    // timer_en dropped while halted: stay HALTED, then IDLE with pre_cnt=0
    dbg_mode = 1'b1;
    halt_req = 1'b1;
    tick();
    expect_all("hd_halt", 2, 1, 0, 1);
    timer_en = 1'b0;
    tick();
    expect_all("hd_hold", 2, 1, 0, 1);
    dbg_mode = 1'b0;
    halt_req = 1'b0;
    #1;
    expect_all("hd_rel", 2, 1, 0, 1);
    tick();
    expect_all("hd_idle", 0, 0, 0, 0);

    // Reset mid-period at pre_cnt=5, then restart
    div_val  = 4'd3;
    timer_en = 1'b1;
    tick();
    expect_all("rs_run", 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) tick();
    expect_all("rs_pre5", 1, 5, 0, 0);
    rst = 1'b1;
    #1;
    expect_all("rs_async", 0, 0, 0, 0);
    tick();
    expect_all("rs_held", 0, 0, 0, 0);
    rst = 1'b0;
    #1;
    tick();
    expect_all("rs_restart", 1, 0, 0, 0);
    tick();
    expect_all("rs_count", 1, 1, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
